wb_regfile_port_ctrl: RTL and testbench
=======================================

WB_REGFILE_PORT_CTRL -- requirements
Module: wb_regfile_port_ctrl

Interface
REQ-001 SHALL have parameter REGS, default 5, meaning register-address width.
REQ-002 SHALL have parameter NB_DATA, default 32, meaning register data width.
REQ-003 SHALL have parameter DRAIN_CYCLES, default 4, meaning number of cycles allowed for in-flight writebacks to retire.
REQ-004 SHALL have one clock and a synchronous, active-high reset; ports i_clk input 1 (clock) and i_reset input 1 (sync active-high reset) come first.
REQ-005 SHALL have i_wb_regwrite input 1, writeback write enable.
REQ-006 SHALL have i_wb_jal input 1, which selects link register 31 as the destination.
REQ-007 SHALL have i_wb_rd input REGS, writeback destination register.
REQ-008 SHALL have i_wb_data input NB_DATA, writeback data.
REQ-009 SHALL have o_rf_we output 1, o_rf_waddr output REGS and o_rf_wdata output NB_DATA, forming the register-file write port.
REQ-010 SHALL have o_rf_raddr output REGS and i_rf_rdata input NB_DATA, forming the register-file debug read port (combinational read).
REQ-011 SHALL have i_dbg_req input 1, a pulse that starts a full register dump.
REQ-012 SHALL have i_dbg_ready input 1, meaning the consumer accepts the current word.
REQ-013 SHALL have o_dbg_valid output 1, o_dbg_addr output REGS and o_dbg_data output NB_DATA, forming the dump stream.
REQ-014 SHALL have o_stall output 1, the pipeline freeze request.
REQ-015 SHALL have o_dbg_busy output 1, asserted while a dump is in progress.
REQ-016 SHALL have o_dbg_done output 1, a one-cycle pulse at the end of a dump.

Function
REQ-017 SHALL register the write port: inputs sampled at edge N appear on o_rf_* during cycle N+1.
REQ-018 SHALL set o_rf_waddr to 31 when i_wb_jal=1, and to i_wb_rd otherwise.
REQ-019 SHALL set o_rf_we to i_wb_regwrite, forced to 0 when the selected address is 0; JAL targets 31, so a JAL write is never suppressed.
REQ-020 SHALL honour writeback writes in every FSM state.
REQ-021 SHALL implement FSM states IDLE, DRAIN, READ, PRESENT and DONE.
REQ-022 SHALL, in IDLE, move to DRAIN on i_dbg_req=1, clearing the drain counter and setting index=0.
REQ-023 SHALL, in DRAIN, count DRAIN_CYCLES cycles and then move to READ.
REQ-024 SHALL, in READ, drive o_rf_raddr=index, capture the word into the data register and move to PRESENT after one cycle.
REQ-025 SHALL, in READ, capture the pending write data instead of i_rf_rdata when the registered write port is writing address index (write forwarding).
REQ-026 SHALL, in PRESENT, drive o_dbg_valid=1, o_dbg_addr=index and o_dbg_data=captured word, all held stable until i_dbg_ready=1.
REQ-027 SHALL, in PRESENT with i_dbg_ready=1, go to DONE if index=31; otherwise increment index and go to READ.
REQ-028 SHALL, in DONE, assert o_dbg_done for one cycle and return to IDLE.
REQ-029 SHALL assert o_stall and o_dbg_busy in DRAIN, READ, PRESENT and DONE, and deassert both in IDLE.
REQ-030 SHALL ignore i_dbg_req outside IDLE.
REQ-031 SHALL produce exactly 32 words, at addresses 0..31 in order, per dump.
REQ-032 SHALL use a 5-bit index that never wraps past 31.
REQ-033 SHALL keep o_dbg_valid at 0 in every state except PRESENT.

Reset
REQ-034 SHALL, on i_reset=1 at a clock edge, set state=IDLE, index=0, drain counter=0 and data register=0.
REQ-035 SHALL hold every output at 0 during reset, including o_rf_we, o_stall, o_dbg_valid, o_dbg_done and o_dbg_busy.
REQ-036 SHALL, on reset mid-dump, abort the dump without emitting o_dbg_done; o_stall is 0 in the cycle after reset.

Structure
REQ-037 SHALL place the FSM state encodings, link-register constant 31 and register count 32 in the shared MIPS package.
REQ-038 SHALL factor the JAL destination select and r0 suppression into the sub-module wb_dest_select; all state lives in this block.

Verification
REQ-039 SHALL verify: regwrite=1, jal=0, rd=7, data=0x1234 -> next cycle we=1, waddr=7, wdata=0x1234.
REQ-040 SHALL verify: regwrite=1, jal=1, rd=3, data=0x00400008 -> next cycle we=1, waddr=31, wdata=0x00400008.
REQ-041 SHALL verify: regwrite=1, jal=0, rd=0 -> we=0.
REQ-042 SHALL verify: dbg_req pulse with ready tied to 1 -> stall=1 from the next cycle, 4 drain cycles, 32 words at addr 0..31, done pulse, stall=0 afterwards; total 4+64+1 cycles in the non-IDLE states after the req edge.
REQ-043 SHALL verify: ready=0 for 10 cycles on word 5 -> valid, addr=5 and data held unchanged, with no skipped or repeated word.
REQ-044 SHALL verify: write r9=0xCAFE landing during READ of index 9 -> o_dbg_data=0xCAFE; and reset asserted at word 12 -> IDLE with no done pulse and stall=0 the next cycle.

Source files
------------

// File: rtl/wb_regfile_port_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile_port_ctrl_pkg
// Description : Shared MIPS constants and the debug-dump FSM state encoding
//               used by the writeback / register-file port controller.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_regfile_port_ctrl_pkg;

    // Architectural register count and the JAL link register
    localparam int          c_NUM_REGS = 32;
    localparam logic [4:0]  c_LINK_REG = 5'd31;

    // Debug-dump sequencer states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRAIN   = 3'd1,
        ST_READ    = 3'd2,
        ST_PRESENT = 3'd3,
        ST_DONE    = 3'd4
    } dump_state_t;

endpackage : wb_regfile_port_ctrl_pkg
`default_nettype wire

// File: rtl/wb_regfile_port_ctrl_dest_select.sv
`default_nettype none
// ============================================================================
// Module      : wb_dest_select
// Description : Writeback destination select. JAL redirects the write to the
//               link register; any write aimed at r0 is suppressed.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_dest_select
    import wb_regfile_port_ctrl_pkg::*;
#(
    parameter int REGS = 5
) (
    input  logic            i_regwrite,
    input  logic            i_jal,
    input  logic [REGS-1:0] i_rd,
    output logic            o_we,
    output logic [REGS-1:0] o_waddr
);

    logic [REGS-1:0] w_addr;

    // JAL always targets the link register, which is never r0
    assign w_addr  = i_jal ? REGS'(c_LINK_REG) : i_rd;
    assign o_we    = i_regwrite && (w_addr != '0);
    assign o_waddr = w_addr;

endmodule : wb_dest_select
`default_nettype wire

// File: rtl/wb_regfile_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile_port_ctrl
// Description : Registered register-file write port for the writeback stage
//               plus a debug sequencer that freezes the pipeline, lets
//               in-flight writebacks retire, and streams all 32 registers
//               out over a valid/ready interface.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_regfile_port_ctrl
    import wb_regfile_port_ctrl_pkg::*;
#(
    parameter int REGS         = 5,
    parameter int NB_DATA      = 32,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic               i_clk,
    input  logic               i_reset,
    // writeback stage
    input  logic               i_wb_regwrite,
    input  logic               i_wb_jal,
    input  logic [REGS-1:0]    i_wb_rd,
    input  logic [NB_DATA-1:0] i_wb_data,
    // register-file write port
    output logic               o_rf_we,
    output logic [REGS-1:0]    o_rf_waddr,
    output logic [NB_DATA-1:0] o_rf_wdata,
    // register-file debug read port (combinational read)
    output logic [REGS-1:0]    o_rf_raddr,
    input  logic [NB_DATA-1:0] i_rf_rdata,
    // debug dump control and stream
    input  logic               i_dbg_req,
    input  logic               i_dbg_ready,
    output logic               o_dbg_valid,
    output logic [REGS-1:0]    o_dbg_addr,
    output logic [NB_DATA-1:0] o_dbg_data,
    output logic               o_stall,
    output logic               o_dbg_busy,
    output logic               o_dbg_done
);

    // A zero drain length still spends one cycle in DRAIN
    localparam int c_DRAIN_LAST = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;
    localparam int c_DRAIN_W    = (c_DRAIN_LAST > 0) ? $clog2(c_DRAIN_LAST + 1) : 1;
    localparam logic [REGS-1:0] c_LAST_INDEX = REGS'(c_NUM_REGS - 1);

    logic                 w_dest_we;
    logic [REGS-1:0]      w_dest_waddr;
    logic                 w_fwd_hit;

    logic                 r_rf_we;
    logic [REGS-1:0]      r_rf_waddr;
    logic [NB_DATA-1:0]   r_rf_wdata;

    dump_state_t          r_state;
    logic [REGS-1:0]      r_index;
    logic [c_DRAIN_W-1:0] r_drain_cnt;
    logic [NB_DATA-1:0]   r_data;
    logic                 r_valid;
    logic                 r_stall;
    logic                 r_done;

    wb_dest_select #(
        .REGS       (REGS)
    ) u_dest_select (
        .i_regwrite (i_wb_regwrite),
        .i_jal      (i_wb_jal),
        .i_rd       (i_wb_rd),
        .o_we       (w_dest_we),
        .o_waddr    (w_dest_waddr)
    );

    // Register the write port; writebacks are honoured regardless of dump state
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
        end else begin
            r_rf_we    <= w_dest_we;
            r_rf_waddr <= w_dest_waddr;
            r_rf_wdata <= i_wb_data;
        end
    end

    // The register file has not yet absorbed a write presented this cycle
    assign w_fwd_hit = r_rf_we && (r_rf_waddr == r_index);

    // Dump sequencer: drain, then read/present each register in order
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_index     <= '0;
            r_drain_cnt <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_stall     <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_valid <= 1'b0;
                    r_done  <= 1'b0;
                    if (i_dbg_req) begin
                        r_state     <= ST_DRAIN;
                        r_drain_cnt <= '0;
                        r_index     <= '0;
                        r_stall     <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (r_drain_cnt == c_DRAIN_W'(c_DRAIN_LAST)) begin
                        r_state <= ST_READ;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 1'b1;
                    end
                end
                ST_READ: begin
                    r_data  <= w_fwd_hit ? r_rf_wdata : i_rf_rdata;
                    r_valid <= 1'b1;
                    r_state <= ST_PRESENT;
                end
                ST_PRESENT: begin
                    if (i_dbg_ready) begin
                        r_valid <= 1'b0;
                        if (r_index == c_LAST_INDEX) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_index <= r_index + 1'b1;
                            r_state <= ST_READ;
                        end
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_stall <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                    r_stall <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_rf_we     = r_rf_we;
    assign o_rf_waddr  = r_rf_waddr;
    assign o_rf_wdata  = r_rf_wdata;
    assign o_rf_raddr  = r_index;
    assign o_dbg_valid = r_valid;
    assign o_dbg_addr  = r_index;
    assign o_dbg_data  = r_data;
    assign o_stall     = r_stall;
    assign o_dbg_busy  = r_stall;
    assign o_dbg_done  = r_done;

endmodule : wb_regfile_port_ctrl
`default_nettype wire

// File: tb/tb_wb_regfile_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_regfile_port_ctrl
// Description : Self-checking bench for wb_regfile_port_ctrl. A simple
//               register-file array is attached to the ports, and an
//               architectural register model predicts every dump word.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_regfile_port_ctrl;

    localparam int REGS         = 5;
    localparam int NB_DATA      = 32;
    localparam int DRAIN_CYCLES = 4;

    logic               i_clk = 1'b0;
    logic               i_reset;
    logic               i_wb_regwrite;
    logic               i_wb_jal;
    logic [REGS-1:0]    i_wb_rd;
    logic [NB_DATA-1:0] i_wb_data;
    logic               o_rf_we;
    logic [REGS-1:0]    o_rf_waddr;
    logic [NB_DATA-1:0] o_rf_wdata;
    logic [REGS-1:0]    o_rf_raddr;
    logic [NB_DATA-1:0] i_rf_rdata;
    logic               i_dbg_req;
    logic               i_dbg_ready;
    logic               o_dbg_valid;
    logic [REGS-1:0]    o_dbg_addr;
    logic [NB_DATA-1:0] o_dbg_data;
    logic               o_stall;
    logic               o_dbg_busy;
    logic               o_dbg_done;

    int tests = 0;
    int fails = 0;

    // architectural register contents as seen by the program
    logic [NB_DATA-1:0] model [32];
    // the physical register file hanging off the DUT ports
    logic [NB_DATA-1:0] rf [32];

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (o_rf_we) begin
            rf[o_rf_waddr] <= o_rf_wdata;
        end
    end
    assign i_rf_rdata = rf[o_rf_raddr];

    wb_regfile_port_ctrl #(
        .REGS         (REGS),
        .NB_DATA      (NB_DATA),
        .DRAIN_CYCLES (DRAIN_CYCLES)
    ) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_wb_regwrite (i_wb_regwrite),
        .i_wb_jal      (i_wb_jal),
        .i_wb_rd       (i_wb_rd),
        .i_wb_data     (i_wb_data),
        .o_rf_we       (o_rf_we),
        .o_rf_waddr    (o_rf_waddr),
        .o_rf_wdata    (o_rf_wdata),
        .o_rf_raddr    (o_rf_raddr),
        .i_rf_rdata    (i_rf_rdata),
        .i_dbg_req     (i_dbg_req),
        .i_dbg_ready   (i_dbg_ready),
        .o_dbg_valid   (o_dbg_valid),
        .o_dbg_addr    (o_dbg_addr),
        .o_dbg_data    (o_dbg_data),
        .o_stall       (o_stall),
        .o_dbg_busy    (o_dbg_busy),
        .o_dbg_done    (o_dbg_done)
    );

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // One writeback; the register-file port must show it one cycle later
    task automatic apply_wb(input logic rw, input logic jal, input logic [4:0] rd,
                            input logic [31:0] data, input string name);
        logic [4:0] exp_addr;
        logic       exp_we;
        i_wb_regwrite = rw;
        i_wb_jal      = jal;
        i_wb_rd       = rd;
        i_wb_data     = data;
        tick();
        exp_addr = jal ? 5'd31 : rd;
        exp_we   = rw && (exp_addr != 5'd0);
        tests++;
        if (o_rf_we !== exp_we) begin
            fails++;
            $display("FAIL %s we: got %b want %b", name, o_rf_we, exp_we);
        end
        if (exp_we) begin
            tests++;
            if (o_rf_waddr !== exp_addr || o_rf_wdata !== data) begin
                fails++;
                $display("FAIL %s port: got addr %0d data %h want addr %0d data %h",
                         name, o_rf_waddr, o_rf_wdata, exp_addr, data);
            end
            model[exp_addr] = data;
        end
        i_wb_regwrite = 1'b0;
    endtask

    // Runs one dump with optional back-pressure, mid-dump write and extra req
    task automatic run_dump(input string name, input int hold_word, input int hold_len,
                            input bit fwd, input bit extra_req, input int exp_cycles);
        int n_busy = 0, n_words = 0, n_done = 0, hold_cnt = 0;
        bit fwd_pending = 0, req_pending = 0, finished = 0;
        logic [4:0]  held_addr;
        logic [31:0] held_data;
        i_dbg_ready = 1'b1;
        i_dbg_req   = 1'b1;
        tick();
        i_dbg_req   = 1'b0;
        tests++;
        if (o_stall !== 1'b1 || o_dbg_busy !== 1'b1) begin
            fails++;
            $display("FAIL %s stall_after_req: got stall %b busy %b want 1 1", name, o_stall, o_dbg_busy);
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (fwd_pending) begin i_wb_regwrite = 1'b0; fwd_pending = 0; end
            if (req_pending) begin i_dbg_req = 1'b0; req_pending = 0; end
            if (!o_stall) begin finished = 1; break; end
            n_busy++;
            if (o_dbg_done) n_done++;
            i_dbg_ready = 1'b1;
            if (o_dbg_valid && o_dbg_addr == 5'(hold_word) && hold_cnt < hold_len) begin
                i_dbg_ready = 1'b0;
                if (hold_cnt == 0) begin
                    held_addr = o_dbg_addr;
                    held_data = o_dbg_data;
                end else begin
                    tests++;
                    if (o_dbg_valid !== 1'b1 || o_dbg_addr !== held_addr || o_dbg_data !== held_data) begin
                        fails++;
                        $display("FAIL %s hold: got v%b addr %0d data %h want v1 addr %0d data %h",
                                 name, o_dbg_valid, o_dbg_addr, o_dbg_data, held_addr, held_data);
                    end
                end
                hold_cnt++;
            end
            if (o_dbg_valid && i_dbg_ready) begin
                tests++;
                if (o_dbg_addr !== 5'(n_words) || o_dbg_data !== model[n_words]) begin
                    fails++;
                    $display("FAIL %s word: got addr %0d data %h want addr %0d data %h",
                             name, o_dbg_addr, o_dbg_data, n_words, model[n_words & 31]);
                end
                if (fwd && n_words == 8) begin
                    i_wb_regwrite = 1'b1; i_wb_jal = 1'b0; i_wb_rd = 5'd9;
                    i_wb_data = 32'h0000_CAFE;
                    model[9] = 32'h0000_CAFE;
                    fwd_pending = 1;
                end
                if (extra_req && n_words == 10) begin
                    i_dbg_req = 1'b1;
                    req_pending = 1;
                end
                n_words++;
            end
            tick();
        end
        i_dbg_req = 1'b0;
        i_wb_regwrite = 1'b0;
        tests++;
        if (!finished || n_busy != exp_cycles) begin
            fails++;
            $display("FAIL %s busy_cycles: got %0d want %0d", name, n_busy, exp_cycles);
        end
        tests++;
        if (n_words != 32 || n_done != 1) begin
            fails++;
            $display("FAIL %s counts: got words %0d done %0d want 32 1", name, n_words, n_done);
        end
        tests++;
        if (o_stall !== 1'b0 || o_dbg_busy !== 1'b0 || o_dbg_valid !== 1'b0 || o_dbg_done !== 1'b0) begin
            fails++;
            $display("FAIL %s idle_after: got stall %b busy %b valid %b done %b want 0 0 0 0",
                     name, o_stall, o_dbg_busy, o_dbg_valid, o_dbg_done);
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        i_wb_regwrite = 1'b1; i_wb_jal = 1'b0; i_wb_rd = 5'd7; i_wb_data = 32'hDEAD_BEEF;
        i_dbg_req = 1'b1; i_dbg_ready = 1'b1;
        for (int i = 0; i < 32; i++) model[i] = '0;
        tick();
        tick();
        tests++;
        if ({o_rf_we, o_stall, o_dbg_valid, o_dbg_done, o_dbg_busy} !== 5'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got we%b stall%b valid%b done%b busy%b want all 0",
                     o_rf_we, o_stall, o_dbg_valid, o_dbg_done, o_dbg_busy);
        end
        tests++;
        if (o_rf_waddr !== '0 || o_rf_wdata !== '0 || o_dbg_addr !== '0 ||
            o_dbg_data !== '0 || o_rf_raddr !== '0) begin
            fails++;
            $display("FAIL reset_data: got waddr %0d wdata %h daddr %0d ddata %h raddr %0d want 0",
                     o_rf_waddr, o_rf_wdata, o_dbg_addr, o_dbg_data, o_rf_raddr);
        end
        i_wb_regwrite = 1'b0;
        i_dbg_req = 1'b0;
        tick();
        i_reset = 1'b0;
        tick();
    endtask

    task automatic test_directed_writes();
        apply_wb(1'b1, 1'b0, 5'd7, 32'h0000_1234, "wb_rd7");
        apply_wb(1'b1, 1'b1, 5'd3, 32'h0040_0008, "wb_jal");
        apply_wb(1'b1, 1'b0, 5'd0, 32'h5555_5555, "wb_r0");
        apply_wb(1'b0, 1'b0, 5'd4, 32'h7777_7777, "wb_off");
        tick();
    endtask

    task automatic test_random_writes();
        for (int i = 0; i < 60; i++) begin
            apply_wb(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
                     5'($urandom_range(0, 31)), 32'($urandom), "wb_rand");
        end
        tick();
    endtask

    task automatic test_dump_basic();
        // a second req mid-dump must be ignored
        run_dump("dump_basic", -1, 0, 1'b0, 1'b1, DRAIN_CYCLES + 64 + 1);
        tick();
    endtask

    task automatic test_backpressure();
        run_dump("dump_hold5", 5, 10, 1'b0, 1'b0, DRAIN_CYCLES + 64 + 1 + 10);
        tick();
    endtask

    task automatic test_forwarding();
        apply_wb(1'b1, 1'b0, 5'd9, 32'h0000_1111, "wb_r9");
        tick();
        run_dump("dump_fwd", -1, 0, 1'b1, 1'b0, DRAIN_CYCLES + 64 + 1);
        tick();
    endtask

    task automatic test_reset_mid_dump();
        bit reached = 0;
        int n_done = 0;
        i_dbg_ready = 1'b1;
        i_dbg_req = 1'b1;
        tick();
        i_dbg_req = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (o_dbg_done) n_done++;
            if (o_dbg_valid && o_dbg_addr == 5'd12) begin reached = 1; break; end
            tick();
        end
        tests++;
        if (!reached) begin
            fails++;
            $display("FAIL rst_mid reach_word12: got timeout want word 12");
        end
        i_dbg_ready = 1'b0;
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        tests++;
        if (o_stall !== 1'b0 || o_dbg_busy !== 1'b0 || o_dbg_valid !== 1'b0 || o_dbg_done !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid after: got stall %b busy %b valid %b done %b want 0 0 0 0",
                     o_stall, o_dbg_busy, o_dbg_valid, o_dbg_done);
        end
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (o_dbg_done) n_done++;
            tests++;
            if (o_stall !== 1'b0) begin
                fails++;
                $display("FAIL rst_mid idle_stall: got %b want 0", o_stall);
            end
            tick();
        end
        tests++;
        if (n_done != 0) begin
            fails++;
            $display("FAIL rst_mid done_pulses: got %0d want 0", n_done);
        end
        i_dbg_ready = 1'b1;
        // the register file was cleared by reset
        for (int i = 0; i < 32; i++) model[i] = '0;
    endtask

    initial begin
        i_reset = 1'b1;
        i_wb_regwrite = 1'b0; i_wb_jal = 1'b0; i_wb_rd = '0; i_wb_data = '0;
        i_dbg_req = 1'b0; i_dbg_ready = 1'b1;
        test_reset();
        test_directed_writes();
        test_random_writes();
        test_dump_basic();
        test_backpressure();
        test_forwarding();
        test_reset_mid_dump();
        test_random_writes();
        test_dump_basic();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_wb_regfile_port_ctrl
`default_nettype wire
